// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first, registered carry.
// Start/ready handshake on the request side, valid/ack handshake on the result side.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub,
    output logic             busy,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             valid,
    input  logic             ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic             carry_q;
    logic             c_msb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fa_s;
    logic             fa_c;

    // Full-adder cell
    always_comb begin
        fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q  <= a_in;
                        b_sh_q  <= b_in ^ {WIDTH{sub}};
                        carry_q <= sub;
                        cnt_q   <= '0;
                        s_sh_q  <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s_sh_q  <= {fa_s, s_sh_q[WIDTH-1:1]};
                    carry_q <= fa_c;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (cnt_q == CNT_W'(WIDTH - 2)) begin
                        c_msb_q <= fa_c;
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ready     = (state_q == ST_IDLE);
        busy      = (state_q == ST_RUN);
        valid     = (state_q == ST_DONE);
        sum_out   = valid ? s_sh_q : '0;
        carry_out = valid & carry_q;
        overflow  = valid & (c_msb_q ^ carry_q);
    end

endmodule
